// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : control FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   LB..SW      : RISC-V funct3 width codes for loads and stores
//   access_bad  : true when a registered access is illegal or misaligned
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal: both access types at once, an unknown load code, or a store
  // code above SW. Misaligned: halfword on an odd byte, word off a word
  // boundary. Width is taken from funct3[1:0] for loads and stores alike.
  function automatic logic access_bad(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = (rd && wr) ||
                 (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
                 (wr && (f3 >= 3'b011));
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle plus the data-memory port of the LSU.
//   req_valid/req_ready, mem_read, mem_write, funct3, addr, store_data : request
//   resp_valid, load_data, access_err                                : response
//   dm_addr (word index), dm_we, dm_be, dm_wd, dm_rd                  : memory
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// && (mem_read || mem_write); the requester holds all request fields stable
// until then. resp_valid is a single-cycle pulse with no back-pressure, and
// load_data/access_err are meaningful only while it is high.
// Modports: slave = the LSU, master = the core plus memory model driving it.
interface lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     store_data;
  logic                  resp_valid;
  logic [DATA_W-1:0]     load_data;
  logic                  access_err;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic                  dm_we;
  logic [3:0]            dm_be;
  logic [DATA_W-1:0]     dm_wd;
  logic [DATA_W-1:0]     dm_rd;

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, store_data, dm_rd,
    output req_ready, resp_valid, load_data, access_err,
           dm_addr, dm_we, dm_be, dm_wd
  );

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, store_data, dm_rd,
    input  req_ready, resp_valid, load_data, access_err,
           dm_addr, dm_we, dm_be, dm_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   funct3, off     : access width code and byte offset within the word
//   store_data      : rs2 value -> wd (replicated onto every lane), be (lanes)
//   rd_data         : memory read word -> ld (shifted and extended load value)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] ld
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    be      = 4'b0000;
    wd      = '0;
    ld      = '0;
    shifted = rd_data >> {off, 3'b000};

    // Replicating the data means the addressed lane always carries the right
    // byte/halfword regardless of offset; be selects which lanes land.
    case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{store_data[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << off;
        wd = {2{store_data[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        wd = store_data;
      end
      default: ;
    endcase

    case (funct3)
      LB:      ld = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LH:      ld = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LW:      ld = shifted;
      LBU:     ld = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LHU:     ld = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ld = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: accepts one core request, performs a single
// memory access against a synchronous-read data memory, then pulses a
// response two cycles after acceptance (one request per three cycles).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response and memory port bundle (slave view)
//   dbg_state  : current FSM state, for observation only
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_if.slave       bus,
  output lsu_state_e dbg_state
);

  lsu_state_e              state_q, state_d;
  logic [DM_ADDRESS+1:0]   addr_q, addr_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_W-1:0]       sd_q, sd_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;

  logic                    bad;
  logic [3:0]              al_be;
  logic [DATA_W-1:0]       al_wd;
  logic [DATA_W-1:0]       al_ld;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (f3_q),
    .off        (addr_q[1:0]),
    .store_data (sd_q),
    .rd_data    (bus.dm_rd),
    .be         (al_be),
    .wd         (al_wd),
    .ld         (al_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      sd_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.mem_read || bus.mem_write)) begin
          addr_d  = bus.addr[DM_ADDRESS+1:0];
          f3_d    = bus.funct3;
          sd_d    = bus.store_data;
          rd_d    = bus.mem_read;
          wr_d    = bus.mem_write;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state, so reset clears them
  // asynchronously (a store caught in ACCESS loses dm_we at once).
  always_comb begin
    bad            = access_bad(rd_q, wr_q, f3_q, addr_q[1:0]);
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.access_err = (state_q == RESP) && bad;
    bus.load_data  = ((state_q == RESP) && rd_q && !bad) ? al_ld : '0;
    // Held between accesses so the memory sees no spurious address churn.
    bus.dm_addr    = addr_q[DM_ADDRESS+1:2];
    bus.dm_we      = (state_q == ACCESS) && wr_q && !bad;
    bus.dm_be      = bus.dm_we ? al_be : 4'b0000;
    bus.dm_wd      = bus.dm_we ? al_wd : '0;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int DMA = 9;
  localparam int NWORDS = 1 << DMA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if #(.DM_ADDRESS(DMA), .DATA_W(32)) bus ();
  lsu_state_e dbg_state;

  lsu_ctrl #(.DM_ADDRESS(DMA), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (synchronous read) ----------------
  logic [31:0] mem [0:NWORDS-1];
  logic [7:0]  ref_b [0:4*NWORDS-1];   // reference byte-addressed image

  always @(posedge clk) begin
    if (bus.dm_we)
      for (int i = 0; i < 4; i++)
        if (bus.dm_be[i]) mem[bus.dm_addr][8*i +: 8] <= bus.dm_wd[8*i +: 8];
    bus.dm_rd <= mem[bus.dm_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  // ---------------- driver + reference model ----------------
  // Called at a falling edge. Presents the request, waits for acceptance,
  // checks the ACCESS cycle and the RESP cycle, and leaves req_valid high.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        output int acc, output logic [31:0] ld_obs);
    int          budget;
    int          size;
    int          ba;
    int          lane0;
    logic        bad;
    logic [31:0] e_ld, e_be, e_wd;

    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ba    = int'(a[DMA+1:0]);
    lane0 = int'(a[1:0]);
    bad   = (rd && wr) ||
            (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
            (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) ||
            ((lane0 % size) != 0);

    e_ld = 32'h0;
    if (rd && !bad) begin
      for (int i = 0; i < size; i++) e_ld |= 32'(ref_b[ba+i]) << (8*i);
      if (!f3[2] && size < 4 && e_ld[8*size-1])
        e_ld |= ~((32'd1 << (8*size)) - 32'd1);
    end
    e_be = 32'h0;
    e_wd = 32'h0;
    if (wr && !bad) begin
      for (int j = lane0; j < lane0 + size; j++) e_be[j] = 1'b1;
      for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = sd[8*(j % size) +: 8];
    end

    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    bus.req_valid  = 1'b1;

    budget = 0;
    while (bus.req_ready !== 1'b1 && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    chk("accept_wait", 32'(budget < 8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;

    // ACCESS
    chk("acc_state",     32'(dbg_state), 32'(ACCESS));
    chk("acc_req_ready", 32'(bus.req_ready), 32'd0);
    chk("acc_resp",      32'(bus.resp_valid), 32'd0);
    chk("acc_dm_addr",   32'(bus.dm_addr), 32'(a[DMA+1:2]));
    chk("acc_dm_we",     32'(bus.dm_we), 32'(wr && !bad));
    if (wr && !bad) begin
      chk("acc_dm_be", 32'(bus.dm_be), e_be);
      chk("acc_dm_wd", bus.dm_wd, e_wd);
    end
    @(negedge clk);

    // RESP
    chk("rsp_valid",     32'(bus.resp_valid), 32'd1);
    chk("rsp_err",       32'(bus.access_err), 32'(bad));
    chk("rsp_load",      bus.load_data, e_ld);
    chk("rsp_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rsp_dm_we",     32'(bus.dm_we), 32'd0);
    chk("rsp_dm_be",     32'(bus.dm_be), 32'd0);
    chk("rsp_dm_wd",     bus.dm_wd, 32'd0);
    ld_obs = bus.load_data;

    if (wr && !bad)
      for (int i = 0; i < size; i++) ref_b[ba+i] = sd[8*i +: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},     32'(dbg_state), 32'(IDLE));
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_resp"},      32'(bus.resp_valid), 32'd0);
    chk({tag, "_load"},      bus.load_data, 32'd0);
    chk({tag, "_err"},       32'(bus.access_err), 32'd0);
    chk({tag, "_dm_we"},     32'(bus.dm_we), 32'd0);
    chk({tag, "_dm_be"},     32'(bus.dm_be), 32'd0);
    chk({tag, "_dm_wd"},     bus.dm_wd, 32'd0);
    chk({tag, "_dm_addr"},   32'(bus.dm_addr), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          acc0, acc1, acc2, rel;
    logic [31:0] ld;
    logic [31:0] w;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
    end

    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;

    // SB to 0x106: lane 2 of word 0x41, replicated data; first edge accepts
    do_req(1'b0, 1'b1, SB, 32'h0000_0106, 32'h0000_00A5, acc0, ld);
    chk("first_accept", 32'(acc0 - rel), 32'd1);

    // Sign/zero-extended byte loads from 0x80FF7F01
    do_req(1'b0, 1'b1, SW, 32'h0000_0200, 32'h80FF7F01, acc0, ld);
    do_req(1'b1, 1'b0, LB, 32'h0000_0203, 32'h0, acc0, ld);
    chk("lb_const", ld, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, LBU, 32'h0000_0203, 32'h0, acc0, ld);
    chk("lbu_const", ld, 32'h00000080);

    // Halfword loads from 0x8001ABCD
    do_req(1'b0, 1'b1, SW, 32'h0000_0210, 32'h8001ABCD, acc0, ld);
    do_req(1'b1, 1'b0, LH, 32'h0000_0212, 32'h0, acc0, ld);
    chk("lh_const", ld, 32'hFFFF8001);
    do_req(1'b1, 1'b0, LHU, 32'h0000_0210, 32'h0, acc0, ld);
    chk("lhu_const", ld, 32'h0000ABCD);

    // Misaligned SW: no write, error response
    do_req(1'b0, 1'b1, SW, 32'h0000_0102, 32'h1234_5678, acc0, ld);
    chk("misal_mem", mem[32'h40], ref_word(32'h40));

    // Back-to-back with req_valid held high
    do_req(1'b1, 1'b0, LW, 32'h0000_0200, 32'h0, acc0, ld);
    do_req(1'b1, 1'b0, LB, 32'h0000_0201, 32'h0, acc1, ld);
    do_req(1'b0, 1'b1, SH, 32'h0000_0012, 32'h0000_BEEF, acc2, ld);
    chk("b2b_gap01", 32'(acc1 - acc0), 32'd3);
    chk("b2b_gap12", 32'(acc2 - acc1), 32'd3);

    // Reset during ACCESS of a SW
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    bus.funct3     = SW;
    bus.addr       = 32'h0000_0300;
    bus.store_data = 32'hDEAD_BEEF;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_acc_we", 32'(bus.dm_we), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    chk("midrst_mem", mem[32'hC0], ref_word(32'hC0));
    rst_n = 1'b1;
    rel = cyc;
    do_req(1'b1, 1'b0, LW, 32'h0000_0300, 32'h0, acc0, ld);
    chk("post_rst_accept", 32'(acc0 - rel), 32'd1);

    // Randomized traffic, biased toward a few words for load-after-store hits
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 9))
        0:             begin rd = 1'b1; wr = 1'b1; end
        1, 2, 3, 4:    begin rd = 1'b1; wr = 1'b0; end
        default:       begin rd = 1'b0; wr = 1'b1; end
      endcase
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd)                   f3 = ($urandom_range(0, 4) == 0) ? LW :
                                          3'($urandom_range(0, 1)) | (3'($urandom_range(0, 1)) << 2);
      else                           f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[DMA+1:2] = 9'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        @(negedge clk);
      end
      do_req(rd, wr, f3, a, $urandom, acc0, ld);
    end

    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NWORDS; i++)
      chk($sformatf("mem_final[%0d]", i), mem[i], ref_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
